// File: rtl/clk_enable_scheduler.sv
// Programmable clock-enable scheduler: periodic tick, square wave, burst/continuous
// sequencing and runtime divisor reconfiguration applied at period boundaries.
module clk_enable_scheduler #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int BURST_W     = 8
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cfg_div,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               clk_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);

  state_t               state, state_next;
  logic [WIDTH-1:0]     count, count_next;
  logic [WIDTH-1:0]     active_div, active_div_next;
  logic [WIDTH-1:0]     shadow, shadow_next;
  logic                 pending, pending_next;
  logic [BURST_W-1:0]   tick_cnt, tick_cnt_next;
  logic [BURST_W-1:0]   burst, burst_next;
  logic                 tick_next, clk_out_next, done_next;
  logic                 apply_shadow;
  logic                 at_wrap;

  assign at_wrap = (count == active_div - WIDTH'(1));

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      active_div <= DIV_RESET;
      shadow     <= DIV_RESET;
      pending    <= 1'b0;
      tick_cnt   <= '0;
      burst      <= '0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= state_next;
      count      <= count_next;
      active_div <= active_div_next;
      shadow     <= shadow_next;
      pending    <= pending_next;
      tick_cnt   <= tick_cnt_next;
      burst      <= burst_next;
      tick       <= tick_next;
      clk_out    <= clk_out_next;
      busy       <= (state_next != IDLE);
      done       <= done_next;
      cfg_ready  <= ~pending_next;
    end
  end

  // Outputs are computed from next-state values so every output stays registered.
  always_comb begin
    state_next      = state;
    count_next      = count;
    active_div_next = active_div;
    shadow_next     = shadow;
    pending_next    = pending;
    tick_cnt_next   = tick_cnt;
    burst_next      = burst;
    tick_next       = 1'b0;
    done_next       = 1'b0;
    apply_shadow    = 1'b0;

    case (state)
      IDLE: begin
        apply_shadow = pending;
        if (start && !stop) begin
          state_next    = RUN;
          count_next    = '0;
          tick_cnt_next = '0;
          burst_next    = burst_len;
        end
      end
      RUN: begin
        if (stop) begin
          state_next   = IDLE;
          count_next   = '0;
          apply_shadow = pending;
        end else if (at_wrap) begin
          count_next    = '0;
          tick_next     = 1'b1;
          tick_cnt_next = tick_cnt + BURST_W'(1);
          apply_shadow  = pending;
          if ((burst != '0) && (tick_cnt_next == burst)) begin
            state_next = FINISH;
          end
        end else begin
          count_next = count + WIDTH'(1);
        end
      end
      FINISH: begin
        state_next   = IDLE;
        done_next    = 1'b1;
        apply_shadow = pending;
      end
      default: state_next = IDLE;
    endcase

    // Transfer and capture are exclusive: capture only happens while nothing is pending.
    if (apply_shadow) begin
      active_div_next = shadow;
      pending_next    = 1'b0;
    end else if (cfg_valid && !pending) begin
      shadow_next  = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
      pending_next = 1'b1;
    end

    clk_out_next = (state_next == RUN) && (count_next >= (active_div_next >> 1));
  end

endmodule
